mm_read_sched: RTL and testbench

//  Read-side scheduler for the banked A/B operand BRAMs of the matrix-multiply engine.
//  - Starts when start_multiply is raised.
//  - Walks every output tile (row-block i, column-block j) and, within each tile, every

---
 rtl/mm_read_sched.sv | 209 ++++++++++++++++++++
 tb/tb_mm_read_sched.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_read_sched.sv
// Read-side address scheduler for the banked A/B operand BRAMs of the matmul engine.
// Optional macro MM_SCHED_PERF_EN adds the perf_cycles run-length counter port.
module mm_read_sched #(
  parameter int unsigned MATRIXSIZE_W = 16,
  parameter int unsigned ADDR_W_A     = 12,
  parameter int unsigned ADDR_W_B     = 12,
  parameter int unsigned DRAIN_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_multiply,
  input  logic [MATRIXSIZE_W-1:0] M2,
  input  logic [MATRIXSIZE_W-1:0] M1dN1,
  input  logic [MATRIXSIZE_W-1:0] M3dN2,
  input  logic                    hold,
  output logic [ADDR_W_A-1:0]     rd_addr_A,
  output logic [ADDR_W_B-1:0]     rd_addr_B,
  output logic                    rd_en,
  output logic                    tile_first,
  output logic                    tile_last,
  output logic                    done_multiply,
  output logic                    busy
`ifdef MM_SCHED_PERF_EN
  ,
  output logic [31:0]             perf_cycles
`endif
);

  localparam int unsigned SW      = MATRIXSIZE_W;
  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [SW-1:0]       m2_q, m2_d, m1_q, m1_d, m3_q, m3_d;
  logic [SW-1:0]       k_q, k_d, j_q, j_d, i_q, i_d;
  logic [ADDR_W_A-1:0] base_a_q, base_a_d, addr_a_q, addr_a_d;
  logic [ADDR_W_B-1:0] base_b_q, base_b_d, addr_b_q, addr_b_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic                rd_en_q, rd_en_d, first_q, first_d, last_q, last_d;
  logic                done_q, done_d, busy_q, busy_d;
  logic                sizes_ok, go_run, last_k, last_j, last_i;

  assign sizes_ok = (M2 != '0) && (M1dN1 != '0) && (M3dN2 != '0);
  assign go_run   = (state_q == S_IDLE) && start_multiply && sizes_ok;
  assign last_k   = (k_q == m2_q - SW'(1));
  assign last_j   = (j_q == m3_q - SW'(1));
  assign last_i   = (i_q == m1_q - SW'(1));

  // Next-state, counter stepping and registered-output values
  always_comb begin
    state_d  = state_q;
    m2_d     = m2_q;
    m1_d     = m1_q;
    m3_d     = m3_q;
    k_d      = k_q;
    j_d      = j_q;
    i_d      = i_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    drain_d  = drain_q;
    rd_en_d  = 1'b0;
    first_d  = 1'b0;
    last_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_multiply) begin
          if (sizes_ok) begin
            state_d  = S_RUN;
            m2_d     = M2;
            m1_d     = M1dN1;
            m3_d     = M3dN2;
            k_d      = '0;
            j_d      = '0;
            i_d      = '0;
            base_a_d = '0;
            base_b_d = '0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (!start_multiply) begin
          state_d = S_IDLE;
        end else if (!hold) begin
          rd_en_d  = 1'b1;
          first_d  = (k_q == '0);
          last_d   = last_k;
          addr_a_d = base_a_q + ADDR_W_A'(k_q);
          addr_b_d = base_b_q + ADDR_W_B'(k_q);
          // Bases advance by M2 so addresses never need a multiplier
          if (last_k) begin
            k_d = '0;
            if (last_j) begin
              j_d      = '0;
              base_b_d = '0;
              if (last_i) begin
                state_d = S_DRAIN;
                drain_d = '0;
              end else begin
                i_d      = i_q + SW'(1);
                base_a_d = base_a_q + ADDR_W_A'(m2_q);
              end
            end else begin
              j_d      = j_q + SW'(1);
              base_b_d = base_b_q + ADDR_W_B'(m2_q);
            end
          end else begin
            k_d = k_q + SW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!start_multiply) begin
          state_d = S_IDLE;
        end else if (drain_q == DRAIN_W'(DRAIN_CYCLES)) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      S_DONE: begin
        if (!start_multiply) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The zero-size shortcut skips one edge of done so it lands a cycle after DONE entry
    done_d = (state_d == S_DONE) && (state_q != S_IDLE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      m2_q     <= '0;
      m1_q     <= '0;
      m3_q     <= '0;
      k_q      <= '0;
      j_q      <= '0;
      i_q      <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      drain_q  <= '0;
      rd_en_q  <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      m2_q     <= m2_d;
      m1_q     <= m1_d;
      m3_q     <= m3_d;
      k_q      <= k_d;
      j_q      <= j_d;
      i_q      <= i_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      drain_q  <= drain_d;
      rd_en_q  <= rd_en_d;
      first_q  <= first_d;
      last_q   <= last_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign rd_addr_A     = addr_a_q;
  assign rd_addr_B     = addr_b_q;
  assign rd_en         = rd_en_q;
  assign tile_first    = first_q;
  assign tile_last     = last_q;
  assign done_multiply = done_q;
  assign busy          = busy_q;

`ifdef MM_SCHED_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Run length in edges from launch to DONE entry, saturating
  always_comb begin
    perf_d = perf_q;
    if (go_run) begin
      perf_d = '0;
    end else if (((state_q == S_RUN) || (state_q == S_DRAIN)) && (perf_q != '1)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) perf_q <= '0;
    else      perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_mm_read_sched.sv
// Scoreboard bench for mm_read_sched: expected address/flag tuples queued at launch,
// popped by a negedge monitor on every rd_en.
module tb_mm_read_sched;

  localparam int unsigned DRAIN = 16;

  typedef struct packed {
    logic [11:0] a;
    logic [11:0] b;
    logic        f;
    logic        l;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_multiply = 1'b0;
  logic        hold = 1'b0;
  logic [15:0] M2 = '0, M1dN1 = '0, M3dN2 = '0;
  logic [11:0] rd_addr_A, rd_addr_B;
  logic        rd_en, tile_first, tile_last, done_multiply, busy;
`ifdef MM_SCHED_PERF_EN
  logic [31:0] perf_cycles;
`endif

  mm_read_sched #(
    .MATRIXSIZE_W(16), .ADDR_W_A(12), .ADDR_W_B(12), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk(clk), .rst(rst), .start_multiply(start_multiply),
    .M2(M2), .M1dN1(M1dN1), .M3dN2(M3dN2), .hold(hold),
    .rd_addr_A(rd_addr_A), .rd_addr_B(rd_addr_B), .rd_en(rd_en),
    .tile_first(tile_first), .tile_last(tile_last),
    .done_multiply(done_multiply), .busy(busy)
`ifdef MM_SCHED_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rd_cnt = 0;
  int   arm = 0;
  int   first_rd = -1;
  int   last_rd = -1;

  always @(posedge clk) cyc = cyc + 1;

  // Monitor: every issued address is checked against the head of the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      n_checks = n_checks + 1;
      if (rd_en === 1'b1) begin
        if (rd_cnt == arm) first_rd = cyc;
        rd_cnt  = rd_cnt + 1;
        last_rd = cyc;
        if (sb.size() == 0) begin
          n_fail = n_fail + 1;
          $display("FAIL sb_unexpected: rd_en with A=%0d B=%0d, required no issue", rd_addr_A, rd_addr_B);
        end else begin
          mon_e = sb.pop_front();
          if ({rd_addr_A, rd_addr_B, tile_first, tile_last} !== mon_e) begin
            n_fail = n_fail + 1;
            $display("FAIL sb_issue: got A=%0d B=%0d f=%b l=%b, required A=%0d B=%0d f=%b l=%b",
                     rd_addr_A, rd_addr_B, tile_first, tile_last, mon_e.a, mon_e.b, mon_e.f, mon_e.l);
          end
        end
      end else if ((tile_first !== 1'b0) || (tile_last !== 1'b0)) begin
        n_fail = n_fail + 1;
        $display("FAIL flags_idle: first=%b last=%b with rd_en=0, required 0 0", tile_first, tile_last);
      end
    end
  end

  task automatic push_model(input int m2, input int m1, input int m3);
    exp_t e;
    for (int i = 0; i < m1; i++)
      for (int j = 0; j < m3; j++)
        for (int k = 0; k < m2; k++) begin
          e.a = 12'(i * m2 + k);
          e.b = 12'(j * m2 + k);
          e.f = (k == 0);
          e.l = (k == m2 - 1);
          sb.push_back(e);
        end
  endtask

  // Launches a run and waits (bounded) for done; d = -1 on timeout
  task automatic run_to_done(input int m2, input int m1, input int m3, input int budget,
                             output int s, output int d);
    @(negedge clk);
    M2 = 16'(m2); M1dN1 = 16'(m1); M3dN2 = 16'(m3);
    push_model(m2, m1, m3);
    arm = rd_cnt;
    s = cyc;
    d = -1;
    start_multiply = 1'b1;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (done_multiply === 1'b1) begin
        d = cyc;
        break;
      end
    end
  endtask

  task automatic drop_start();
    start_multiply = 1'b0;
    @(negedge clk);
    n_checks = n_checks + 1;
    if ({done_multiply, busy} !== 2'b00) begin
      n_fail = n_fail + 1;
      $display("FAIL drop_start: done=%b busy=%b, required 0 0", done_multiply, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks = n_checks + 1;
    if ({rd_addr_A, rd_addr_B, rd_en, tile_first, tile_last, done_multiply, busy} !== '0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_outputs: A=%0d B=%0d en=%b done=%b busy=%b, required all 0",
               rd_addr_A, rd_addr_B, rd_en, done_multiply, busy);
    end
`ifdef MM_SCHED_PERF_EN
    n_checks = n_checks + 1;
    if (perf_cycles !== 32'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_perf: got %0d, required 0", perf_cycles);
    end
`endif
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_tile();
    int s, d;
    run_to_done(3, 1, 1, 200, s, d);
    n_checks = n_checks + 4;
    if (rd_cnt - arm != 3) begin
      n_fail = n_fail + 1;
      $display("FAIL single_count: got %0d rd_en, required 3", rd_cnt - arm);
    end
    if (first_rd != s + 2) begin
      n_fail = n_fail + 1;
      $display("FAIL single_first_latency: first rd_en edge %0d, required %0d", first_rd, s + 2);
    end
    if (d - last_rd != int'(DRAIN) + 1) begin
      n_fail = n_fail + 1;
      $display("FAIL single_done_latency: got %0d edges, required %0d", d - last_rd, DRAIN + 1);
    end
    if (sb.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL single_sb_left: %0d pending, required 0", sb.size());
    end
`ifdef MM_SCHED_PERF_EN
    n_checks = n_checks + 1;
    if (perf_cycles !== 32'(3 + DRAIN + 1)) begin
      n_fail = n_fail + 1;
      $display("FAIL perf_single: got %0d, required %0d", perf_cycles, 3 + DRAIN + 1);
    end
`endif
    // Start still high in DONE must not retrigger; the monitor flags any stray rd_en
    repeat (5) @(negedge clk);
    n_checks = n_checks + 1;
    if ({done_multiply, busy} !== 2'b11) begin
      n_fail = n_fail + 1;
      $display("FAIL done_hold: done=%b busy=%b, required 1 1", done_multiply, busy);
    end
    drop_start();
`ifdef MM_SCHED_PERF_EN
    n_checks = n_checks + 1;
    if (perf_cycles !== 32'(3 + DRAIN + 1)) begin
      n_fail = n_fail + 1;
      $display("FAIL perf_idle_hold: got %0d, required %0d", perf_cycles, 3 + DRAIN + 1);
    end
`endif
  endtask

  task automatic test_multi(input int m2, input int m1, input int m3, input int budget);
    int s, d;
    run_to_done(m2, m1, m3, budget, s, d);
    n_checks = n_checks + 3;
    if (rd_cnt - arm != m1 * m2 * m3) begin
      n_fail = n_fail + 1;
      $display("FAIL multi_count_%0dx%0dx%0d: got %0d, required %0d", m2, m1, m3, rd_cnt - arm, m1 * m2 * m3);
    end
    if (d - last_rd != int'(DRAIN) + 1) begin
      n_fail = n_fail + 1;
      $display("FAIL multi_done_latency_%0dx%0dx%0d: got %0d, required %0d", m2, m1, m3, d - last_rd, DRAIN + 1);
    end
    if (sb.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL multi_sb_left_%0dx%0dx%0d: %0d pending, required 0", m2, m1, m3, sb.size());
    end
    drop_start();
  endtask

  task automatic test_hold();
    int  d;
    bit  seen;
    @(negedge clk);
    M2 = 16'd4; M1dN1 = 16'd1; M3dN2 = 16'd1;
    push_model(4, 1, 1);
    arm = rd_cnt;
    seen = 1'b0;
    start_multiply = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (rd_en === 1'b1 && rd_addr_A == 12'd1) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks = n_checks + 1;
    if (!seen) begin
      n_fail = n_fail + 1;
      $display("FAIL hold_second_addr: address 1 not seen, required within 20 cycles");
    end
    hold = 1'b1;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      n_checks = n_checks + 1;
      if (rd_en !== 1'b0) begin
        n_fail = n_fail + 1;
        $display("FAIL hold_gap%0d: rd_en=%b, required 0", t, rd_en);
      end
    end
    hold = 1'b0;
    d = -1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (done_multiply === 1'b1) begin
        d = cyc;
        break;
      end
    end
    n_checks = n_checks + 2;
    if (rd_cnt - arm != 4 || sb.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL hold_count: got %0d issued %0d pending, required 4 and 0", rd_cnt - arm, sb.size());
    end
    if (d - last_rd != int'(DRAIN) + 1) begin
      n_fail = n_fail + 1;
      $display("FAIL hold_done_latency: got %0d, required %0d", d - last_rd, DRAIN + 1);
    end
    drop_start();
  endtask

  task automatic test_zero_size();
    int s, d;
    run_to_done(3, 0, 2, 20, s, d);
    n_checks = n_checks + 2;
    if (d != s + 2) begin
      n_fail = n_fail + 1;
      $display("FAIL zero_done_edge: done at edge %0d, required %0d", d, s + 2);
    end
    if (rd_cnt - arm != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL zero_no_issue: got %0d rd_en, required 0", rd_cnt - arm);
    end
    drop_start();
  endtask

  task automatic test_abort();
    int  s, d;
    bit  seen, done_seen;
    @(negedge clk);
    M2 = 16'd3; M1dN1 = 16'd1; M3dN2 = 16'd2;
    push_model(3, 1, 2);
    arm = rd_cnt;
    seen = 1'b0;
    start_multiply = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (rd_en === 1'b1 && rd_addr_A == 12'd1) begin
        seen = 1'b1;
        break;
      end
    end
    start_multiply = 1'b0;
    @(negedge clk);
    n_checks = n_checks + 2;
    if (!seen || {rd_en, busy, done_multiply} !== 3'b000) begin
      n_fail = n_fail + 1;
      $display("FAIL abort_idle: seen=%b en=%b busy=%b done=%b, required 1 0 0 0", seen, rd_en, busy, done_multiply);
    end
    if (sb.size() != 4) begin
      n_fail = n_fail + 1;
      $display("FAIL abort_issued: %0d pending, required 4", sb.size());
    end
    sb.delete();
    done_seen = 1'b0;
    repeat (DRAIN + 4) begin
      @(negedge clk);
      if (done_multiply !== 1'b0) done_seen = 1'b1;
    end
    n_checks = n_checks + 1;
    if (done_seen) begin
      n_fail = n_fail + 1;
      $display("FAIL abort_done: done rose after abort, required 0");
    end
    run_to_done(2, 1, 1, 60, s, d);
    n_checks = n_checks + 1;
    if (rd_cnt - arm != 2 || first_rd != s + 2 || sb.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL abort_restart: count %0d first %0d pending %0d, required 2 %0d 0",
               rd_cnt - arm, first_rd, sb.size(), s + 2);
    end
    drop_start();
  endtask

  task automatic test_async_reset();
    bit seen;
    @(negedge clk);
    M2 = 16'd4; M1dN1 = 16'd2; M3dN2 = 16'd2;
    push_model(4, 2, 2);
    arm = rd_cnt;
    seen = 1'b0;
    start_multiply = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (rd_en === 1'b1 && rd_addr_A == 12'd2) begin
        seen = 1'b1;
        break;
      end
    end
    #2 rst = 1'b0;
    #1;
    n_checks = n_checks + 1;
    if (!seen || {rd_addr_A, rd_addr_B, rd_en, tile_first, tile_last, done_multiply, busy} !== '0) begin
      n_fail = n_fail + 1;
      $display("FAIL async_reset: seen=%b A=%0d B=%0d en=%b busy=%b, required 1 and all 0",
               seen, rd_addr_A, rd_addr_B, rd_en, busy);
    end
    sb.delete();
    start_multiply = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks = n_checks + 1;
    if ({rd_en, busy, done_multiply} !== 3'b000) begin
      n_fail = n_fail + 1;
      $display("FAIL post_reset_idle: en=%b busy=%b done=%b, required 0 0 0", rd_en, busy, done_multiply);
    end
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_multi(2, 2, 2, 100);
    test_multi(1, 2, 3, 100);
    test_multi(2048, 3, 1, 7000);
    test_hold();
    test_zero_size();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
